// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant codes and
// default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection: data wins unless it has already taken MAX_D_STREAK
// consecutive grants while a fetch was waiting.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int SW           = $clog2(MAX_D_STREAK + 1)
) (
    input  logic          i_effIf,
    input  logic          i_effD,
    input  logic [SW-1:0] i_streak,
    output grant_t        o_grant
);

    always_comb begin
        o_grant = GNT_NONE;
        if (i_effD && i_effIf) begin
            o_grant = (i_streak == SW'(MAX_D_STREAK)) ? GNT_I : GNT_D;
        end else if (i_effD) begin
            o_grant = GNT_D;
        end else if (i_effIf) begin
            o_grant = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the IF and MEM pipeline stages; one
// transaction in flight, registered acks and anti-starvation streak counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    state_t            r_state;
    logic [SW-1:0]     r_streak;
    logic              r_ifAck;
    logic              r_dAck;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_busy;

    logic   w_effIf;
    logic   w_effD;
    grant_t w_grant;

    // A request still high in its own ack cycle must not be granted again.
    assign w_effIf = if_req_i & ~r_ifAck;
    assign w_effD  = d_req_i & ~r_dAck;

    mem_arb_select #(
        .MAX_D_STREAK(MAX_D_STREAK),
        .SW          (SW)
    ) u_select (
        .i_effIf (w_effIf),
        .i_effD  (w_effD),
        .i_streak(r_streak),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_streak   <= '0;
            r_ifAck    <= 1'b0;
            r_dAck     <= 1'b0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ifAck <= 1'b0;
            r_dAck  <= 1'b0;
            case (r_state)
                IDLE: begin
                    case (w_grant)
                        GNT_D: begin
                            r_memAddr  <= d_addr_i;
                            r_memWe    <= d_we_i;
                            r_memWdata <= d_wdata_i;
                            r_memReq   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= BUSY_D;
                            if (w_effIf && (r_streak != SW'(MAX_D_STREAK))) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end
                        GNT_I: begin
                            r_memAddr <= if_addr_i;
                            r_memWe   <= 1'b0;
                            r_memReq  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= BUSY_I;
                            r_streak  <= '0;
                        end
                        default: ;
                    endcase
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready_i) begin
                        if (r_state == BUSY_I) begin
                            r_ifAck   <= 1'b1;
                            r_ifRdata <= mem_rdata_i;
                        end else begin
                            r_dAck <= 1'b1;
                            if (!r_memWe) begin
                                r_dRdata <= mem_rdata_i;
                            end
                        end
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_ack_o    = r_ifAck;
    assign if_rdata_o  = r_ifRdata;
    assign d_ack_o     = r_dAck;
    assign d_rdata_o   = r_dRdata;
    assign mem_req_o   = r_memReq;
    assign mem_we_o    = r_memWe;
    assign mem_addr_o  = r_memAddr;
    assign mem_wdata_o = r_memWdata;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model plus an ordered
// scoreboard of expected acks, with cycle-exact checks around it.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        busy_o;

    mem_arbiter dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_ack_o   (if_ack_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ack_o    (d_ack_o),
        .d_rdata_o  (d_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          isData;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expQ[$];
    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [31:0] lastDRead   = 32'd0;
    logic [31:0] memArr[logic [31:0]];
    int          memLat      = 0;
    int          memCnt      = 0;
    bit          forceReady  = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memPeek(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Drive one requester; when the ack is expected, queue its outcome.
    task automatic applyStimulus(input bit isData, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expectAck);
        exp_t e;
        if (isData) begin
            d_req_i   = 1'b1;
            d_we_i    = we;
            d_addr_i  = addr;
            d_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end
        if (expectAck) begin
            e.isData = isData;
            if (isData && we) begin
                e.rdata = lastDRead;
            end else begin
                e.rdata = memPeek(addr);
            end
            if (isData && !we) lastDRead = e.rdata;
            expQ.push_back(e);
        end
    endtask

    task automatic waitAck(input bit isData);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (isData ? d_ack_o : if_ack_o) return;
        end
        checkOutput("ack_timeout", isData ? d_ack_o : if_ack_o, 1);
    endtask

    // Memory model: answers after memLat busy cycles; writes land on ready.
    always @(negedge clk_i) begin
        if (mem_req_o) begin
            if (memCnt == memLat) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = memPeek(mem_addr_o);
                if (mem_we_o) memArr[mem_addr_o] = mem_wdata_o;
            end else begin
                mem_ready_i = 1'b0;
                memCnt++;
            end
        end else begin
            memCnt      = 0;
            mem_ready_i = forceReady;
            if (forceReady) mem_rdata_i = 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk_i) begin
        if (if_ack_o || d_ack_o) begin
            if (if_ack_o && d_ack_o) begin
                checkOutput("dual_ack", {if_ack_o, d_ack_o}, 2'b00);
            end else if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", {if_ack_o, d_ack_o}, 2'b00);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("ack_kind", d_ack_o, e.isData);
                checkOutput("ack_rdata", d_ack_o ? d_rdata_o : if_rdata_o, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        memArr[32'h10] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("rst_outputs",
                    {if_ack_o, d_ack_o, mem_req_o, mem_we_o, busy_o, mem_addr_o}, 0);
        checkOutput("rst_data", {if_rdata_o, d_rdata_o}, 0);
        checkOutput("rst_wdata", mem_wdata_o, 0);

        $display("[TB] single fetch");
        memLat = 0;
        @(negedge clk_i);
        applyStimulus(0, 0, 32'h10, 0, 1);
        @(negedge clk_i);
        checkOutput("fetch_memreq_c1", {mem_req_o, busy_o, mem_we_o}, 3'b110);
        checkOutput("fetch_addr_c1", mem_addr_o, 32'h10);
        @(negedge clk_i);
        checkOutput("fetch_ack_c2", if_ack_o, 1);
        checkOutput("fetch_rdata_c2", if_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        if_req_i = 1'b0;
        checkOutput("fetch_no_regrant", {mem_req_o, if_ack_o}, 2'b00);

        $display("[TB] simultaneous requests");
        @(negedge clk_i);
        applyStimulus(1, 0, 32'h80, 0, 1);
        applyStimulus(0, 0, 32'h40, 0, 1);
        @(negedge clk_i);
        checkOutput("sim_d_first", {mem_req_o, mem_addr_o}, {1'b1, 32'h80});
        @(negedge clk_i);
        checkOutput("sim_dack_c2", d_ack_o, 1);
        d_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("sim_i_granted", {mem_req_o, mem_addr_o}, {1'b1, 32'h40});
        @(negedge clk_i);
        checkOutput("sim_iack_c4", if_ack_o, 1);
        if_req_i = 1'b0;

        $display("[TB] data write with slow memory");
        memLat = 3;
        @(negedge clk_i);
        applyStimulus(1, 1, 32'h20, 32'h55, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput("wr_we_held", {mem_req_o, mem_we_o, d_ack_o}, 3'b110);
            checkOutput("wr_wdata_held", mem_wdata_o, 32'h55);
        end
        @(negedge clk_i);
        checkOutput("wr_ack_c5", d_ack_o, 1);
        checkOutput("wr_rdata_kept", d_rdata_o, lastDRead);
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        memLat  = 1;
        @(negedge clk_i);
        applyStimulus(1, 0, 32'h20, 0, 1);
        waitAck(1);
        checkOutput("rd_back", d_rdata_o, 32'h55);
        d_req_i = 1'b0;

        $display("[TB] spurious ready in idle");
        @(negedge clk_i);
        forceReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("spur_idle", {mem_req_o, busy_o, if_ack_o, d_ack_o}, 4'b0000);
        end
        forceReady = 1'b0;

        // Fetch withdraws after each data ack so every round starts with both
        // requests fresh in IDLE, walking the streak up to its bound.
        $display("[TB] starvation bound");
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 5; r++) begin
                @(negedge clk_i);
                if (r < 4) begin
                    applyStimulus(1, 0, 32'h200 + 32'(r * 4), 0, 1);
                    applyStimulus(0, 0, 32'h100 + 32'(r * 4), 0, 0);
                    waitAck(1);
                    if_req_i = 1'b0;
                    d_req_i  = 1'b0;
                end else begin
                    applyStimulus(0, 0, 32'h180 + 32'(pass * 4), 0, 1);
                    applyStimulus(1, 0, 32'h280 + 32'(pass * 4), 0, 1);
                    waitAck(0);
                    if_req_i = 1'b0;
                    waitAck(1);
                    d_req_i = 1'b0;
                end
            end
        end

        $display("[TB] reset mid-operation");
        memLat = 6;
        @(negedge clk_i);
        applyStimulus(1, 0, 32'h300, 0, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("abort_busy_before", {mem_req_o, busy_o}, 2'b11);
        rst_i   = 1'b1;
        d_req_i = 1'b0;
        void'(expQ.pop_back());
        lastDRead = 32'd0;
        @(negedge clk_i);
        checkOutput("abort_idle", {mem_req_o, busy_o, d_ack_o, mem_we_o}, 4'b0000);
        checkOutput("abort_rdata", d_rdata_o, 0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        checkOutput("abort_no_ack", {mem_req_o, d_ack_o}, 2'b00);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined CPU.
- Sequences one memory transaction at a time and returns a registered acknowledge to the granted requester.
- Data accesses get priority, with a bounded-streak rule so fetch is never starved.
- Sits between the pipeline stages and the memory model; requesters stall while their req is pending and no ack has arrived.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (must be >= 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  DATA_W  fetched instruction; valid with if_ack_o, held until the next fetch ack.
- d_req_i  in  1  data request; held high until d_ack_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  write data.
- d_ack_o  out  1  one-cycle data completion pulse.
- d_rdata_o  out  DATA_W  read data; updated only on read acks.
- mem_req_o  out  1  memory access in progress.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ready_i.
- mem_ready_i  in  1  memory completes the current access this cycle.
- busy_o  out  1  high in BUSY_I or BUSY_D.

Behaviour:
- Reset: all outputs are 0, state is IDLE, streak counter is 0. This applies mid-transaction too: the in-flight access is abandoned, no ack is ever issued for it, and the memory is reset alongside.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, effective requests:
  - eff_if = if_req_i & ~if_ack_o.
  - eff_d = d_req_i & ~d_ack_o.
  - A req still high during its own ack cycle is therefore not re-granted.
- IDLE, grant selection:
  - Only eff_d: grant D.
  - Only eff_if: grant I.
  - Both: grant I if streak == MAX_D_STREAK, else grant D.
- Grant actions:
  - Latch addr, and for D also we and wdata, into mem_addr_o, mem_we_o and mem_wdata_o.
  - Set mem_req_o = 1 and move to BUSY_I or BUSY_D.
  - For I grants, mem_we_o = 0 and mem_wdata_o keeps its previous value.
  - Requester inputs changing after the grant are ignored.
- Streak counter:
  - Increments on each D grant made while eff_if is high, saturating at MAX_D_STREAK.
  - Clears on any I grant.
  - Unchanged on a D grant with no fetch pending.
- BUSY_x:
  - mem_req_o and the latched address/data stay stable until mem_ready_i.
  - On mem_ready_i, the next edge gives: ack_x = 1 for one cycle, rdata_x <= mem_rdata_i (D writes leave d_rdata_o unchanged), mem_req_o = 0, mem_we_o = 0, state = IDLE.
- mem_ready_i is ignored in IDLE.
- Latency: req is seen in IDLE in cycle 0, mem_req_o is high from cycle 1, ready arrives in cycle 1+k (k >= 0), and ack is high in cycle 2+k. The minimum is 3 cycles request-to-ack.
- Back-to-back: a new grant can be made in the ack cycle, so memory sees one idle cycle between accesses.
- Only one transaction is outstanding at a time; there is no queuing.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants IDLE/BUSY_I/BUSY_D (2 bits);
  - default ADDR_W/DATA_W;
  - grant encoding GNT_NONE/GNT_I/GNT_D.
- One combinational sub-module, mem_arb_select.
  - Inputs: eff_if, eff_d, streak, MAX_D_STREAK.
  - Output: grant code.
- The top module holds the FSM, latches and counter.

Test Plan:
- Single fetch:
  - Stimulus: if_req_i=1 with addr 0x10 in cycle 0; memory ready in cycle 1 with rdata 0xDEADBEEF.
  - Response: mem_req_o=1 in cycle 1 with mem_addr_o=0x10; if_ack_o=1 and if_rdata_o=0xDEADBEEF in cycle 2; no second grant while if_req_i is still high in cycle 2.
- Simultaneous requests:
  - Stimulus: if_req (0x40) and d_req read (0x80) in the same cycle; memory ready immediately.
  - Response: D is served first (mem_addr_o=0x80); d_ack in cycle 2; I is granted in cycle 2; if_ack in cycle 4.
- Starvation bound:
  - Stimulus: MAX_D_STREAK=4, d_req re-asserted continuously, if_req held.
  - Response: grant order D, D, D, D, I, D; streak is 0 after the I grant.
- Data write:
  - Stimulus: d_we=1, addr 0x20, wdata 0x55; memory ready after k=3.
  - Response: mem_we_o=1 and mem_wdata_o=0x55 for 4 cycles; d_ack in cycle 5; d_rdata_o keeps its prior value.
- Reset mid-operation:
  - Stimulus: rst_i in cycle 2 of BUSY_D; memory ready later.
  - Response: next cycle shows mem_req_o=0, busy_o=0 and state IDLE; no d_ack for the aborted request.
- Spurious ready:
  - Stimulus: mem_ready_i=1 in IDLE with no requests.
  - Response: no ack and no state change.
